// File: rtl/toggle_responder.sv
// toggle_responder: receive side of a two-phase (toggle) req/ack link.
// Each level change on req_t becomes one evt pulse plus one valid/ready beat;
// acceptance by the consumer toggles ack_t back and bumps xfer_count.
// Optional macro TOGGLE_RESPONDER_SYNC_EN: adds a 2-flop synchronizer on req_t.
module toggle_responder #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               req_t,
  input  logic [WIDTH-1:0]   data_in,
  output logic               ack_t,
  output logic               evt,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] xfer_count,
  output logic               overrun
);

  typedef enum logic {IDLE, VALID} state_t;

  state_t               state_q, state_d;
  logic                 req_s;
  logic                 req_seen_q, req_seen_d;
  logic                 req_prev_q, req_prev_d;
  logic                 ack_q, ack_d;
  logic                 evt_q, evt_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;

`ifdef TOGGLE_RESPONDER_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Two-stage shift of the asynchronous request toggle.
  always_comb sync_d = {sync_q[0], req_t};

  // Synchronizer flops; cleared so a held-high req_t re-arms after clr.
  always_ff @(posedge clk) begin
    if (clr) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign req_s = sync_q[1];
`else
  assign req_s = req_t;
`endif

  // Next-state: detect in IDLE, hand off in VALID, flag any toggle while busy.
  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    req_prev_d = req_s;
    ack_d      = ack_q;
    evt_d      = 1'b0;
    data_d     = data_q;
    cnt_d      = cnt_q;
    ovr_d      = ovr_q;
    case (state_q)
      IDLE: begin
        if (req_s != req_seen_q) begin
          data_d     = data_in;
          req_seen_d = req_s;
          evt_d      = 1'b1;
          state_d    = VALID;
        end
      end
      VALID: begin
        // A second toggle before the ack is a protocol error; it is only flagged.
        if (req_s != req_prev_q) ovr_d = 1'b1;
        if (out_ready) begin
          ack_d   = req_seen_q;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      req_seen_q <= 1'b0;
      req_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      evt_q      <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      req_prev_q <= req_prev_d;
      ack_q      <= ack_d;
      evt_q      <= evt_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
    end
  end

  assign ack_t      = ack_q;
  assign evt        = evt_q;
  assign out_data   = data_q;
  assign out_valid  = (state_q == VALID);
  assign xfer_count = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_toggle_responder.sv
// Bench for toggle_responder: directed scenarios with literal expectations,
// plus a transfer-level reference model compared every cycle.
module tb_toggle_responder;
  localparam int W  = 8;
  localparam int CW = 4;
`ifdef TOGGLE_RESPONDER_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic          clk = 0;
  logic          clr = 1;
  logic          req_t = 0;
  logic [W-1:0]  data_in = '0;
  logic          out_ready = 0;
  logic          ack_t, evt, out_valid, overrun;
  logic [W-1:0]  out_data;
  logic [CW-1:0] xfer_count;

  int checks = 0;
  int errors = 0;
  bit armed = 0;
  int evt_cnt = 0;
  logic [W-1:0] got_q[$];

  toggle_responder #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .clr(clr), .req_t(req_t), .data_in(data_in), .ack_t(ack_t),
    .evt(evt), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .xfer_count(xfer_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: requests seen after L cycles of delay; one pending beat at a time.
  logic         m_seen = 0, m_prev = 0, m_valid = 0, m_ack = 0, m_evt = 0, m_ovr = 0;
  logic [W-1:0] m_data = '0;
  int           m_cnt = 0;
  logic [1:0]   m_pipe = '0;

  always @(posedge clk) begin
    logic rs;
    if (clr) begin
      m_seen = 0; m_prev = 0; m_valid = 0; m_ack = 0; m_evt = 0; m_ovr = 0;
      m_data = '0; m_cnt = 0; m_pipe = '0;
    end else begin
      rs = (L == 0) ? req_t : m_pipe[1];
      m_evt = 0;
      if (!m_valid) begin
        if (rs != m_seen) begin
          m_data = data_in; m_seen = rs; m_evt = 1; m_valid = 1;
        end
      end else begin
        if (rs != m_prev) m_ovr = 1;
        if (out_ready) begin
          m_valid = 0; m_ack = m_seen; m_cnt = (m_cnt + 1) % (1 << CW);
        end
      end
      m_prev = rs;
      m_pipe = {m_pipe[0], req_t};
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("ack_t", ack_t, m_ack);
      chk("evt", evt, m_evt);
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("xfer_count", xfer_count, m_cnt);
      chk("overrun", overrun, m_ovr);
      if (evt) begin
        evt_cnt++;
        got_q.push_back(out_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_clr();
    clr = 1; req_t = 0; out_ready = 0;
    tick(); tick();
    clr = 0;
  endtask

  // One full transfer with ready held high; bounded wait on the ack toggle.
  task automatic xfer(input logic [W-1:0] d);
    int n = 0;
    data_in = d;
    req_t = ~req_t;
    while (ack_t !== req_t && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("ack_timeout", ack_t, req_t);
  endtask

  initial begin
    // Reset and quiet period.
    clr = 1;
    tick();
    armed = 1;
    tick();
    clr = 0;
    chk("rst_ack", ack_t, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", xfer_count, 0);
    chk("rst_overrun", overrun, 0);
    repeat (10) tick();
    chk("idle_no_evt", evt_cnt, 0);

    // Single transfer with ready delayed.
    data_in = 8'hA5; req_t = 1; out_ready = 0;
    repeat (L + 1) tick();
    chk("single_evt", evt, 1);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'hA5);
    tick(); tick();
    chk("single_evt_once", evt_cnt, 1);
    chk("single_hold_valid", out_valid, 1);
    chk("single_hold_data", out_data, 8'hA5);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("single_ack", ack_t, 1);
    chk("single_count", xfer_count, 1);
    chk("single_valid_fall", out_valid, 0);

    // Back-to-back, ready tied high.
    do_clr();
    got_q.delete();
    out_ready = 1;
    for (int k = 1; k <= 5; k++) xfer(k[W-1:0]);
    tick();
    chk("b2b_nbeats", got_q.size(), 5);
    for (int k = 0; k < 5 && k < got_q.size(); k++) chk("b2b_data", got_q[k], k + 1);
    chk("b2b_count", xfer_count, 5);
    chk("b2b_ack", ack_t, 1);
    chk("b2b_overrun", overrun, 0);

    // Overrun: double toggle while busy.
    do_clr();
    data_in = 8'h3C; req_t = 1;
    repeat (L + 1) tick();
    chk("ovr_valid", out_valid, 1);
    req_t = 0; tick();
    req_t = 1; tick();
    repeat (L + 1) tick();
    chk("ovr_set", overrun, 1);
    out_ready = 1; tick(); out_ready = 0;
    chk("ovr_after_beat", overrun, 1);
    chk("ovr_beat_done", out_valid, 0);
    repeat (4) tick();
    chk("ovr_sticky", overrun, 1);
    chk("ovr_lost_toggle", out_valid, 0);
    do_clr();
    chk("ovr_cleared", overrun, 0);

    // Counter wrap at COUNT_W=4.
    out_ready = 1;
    for (int k = 0; k < 17; k++) xfer(k[W-1:0]);
    tick();
    chk("wrap_count", xfer_count, 1);

    // Mid-transfer reset with req_t left high.
    do_clr();
    data_in = 8'h5A; req_t = 1;
    repeat (L + 1) tick();
    chk("mid_valid", out_valid, 1);
    clr = 1;
    tick();
    chk("mid_clr_valid", out_valid, 0);
    chk("mid_clr_ack", ack_t, 0);
    clr = 0;
    evt_cnt = 0;
    repeat (L + 1) tick();
    chk("mid_reevt", evt, 1);
    chk("mid_reevt_data", out_data, 8'h5A);
    out_ready = 1; tick(); out_ready = 0;

    // Short random phase checked by the model only.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_t = ~req_t;
        data_in = W'($urandom);
      end
      out_ready = $urandom_range(0, 1);
      clr = ($urandom_range(0, 60) == 0);
      tick();
    end
    clr = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
